cmul7p8_sched: RTL and testbench



---
 rtl/cmul7p8_sched.sv | 204 ++++++++++++++++++++
 tb/tb_cmul7p8_sched.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cmul7p8_sched.sv
// Shared multi-cycle 7/8 scaler serving N requesters.
// A single shift-add datapath is sequenced by a 3-step FSM. The result is returned
// over a valid/ready handshake.
// Optional macro CMUL7P8_RR_EN: when defined, arbitration is round-robin.
// When undefined, arbitration is fixed priority and the lowest index wins.
module cmul7p8_sched #(
  parameter int unsigned N   = 4,
  parameter int unsigned W   = 5,
  parameter int unsigned IDW = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   x_in,
  input  logic [2*N-1:0]   mode_in,
  output logic [N-1:0]     ack,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_y,
  output logic [IDW-1:0]   out_id
);

  localparam int unsigned DW = W + 4;

  typedef enum logic [2:0] {StIdle, StS1, StS2, StS3, StDone} state_e;

  state_e                r_state;
  logic signed [W-1:0]   r_x;
  logic [1:0]            r_mode;
  logic [IDW-1:0]        r_id;
  logic signed [DW-1:0]  r_acc;
  logic signed [DW-1:0]  r_tmp;
  logic [N-1:0]          r_ack;
  logic                  r_busy;
  logic                  r_out_valid;
  logic [W-1:0]          r_out_y;
  logic [IDW-1:0]        r_out_id;

  logic                  w_grant_vld;
  logic [IDW-1:0]        w_grant;
  logic [W-1:0]          w_x_sel;
  logic [1:0]            w_mode_sel;
  logic signed [DW-1:0]  w_x_ext;
  logic signed [DW-1:0]  w_acc_d;
  logic signed [DW-1:0]  w_tmp_d;

  // Divide by 2^s, truncating toward zero: bias negative values before the arithmetic shift.
  function automatic logic signed [DW-1:0] f_div(input logic signed [DW-1:0] v,
                                                 input int unsigned s);
    logic signed [DW-1:0] bias;
    bias = v[DW-1] ? signed'((DW'(1) << s) - DW'(1)) : '0;
    return (v + bias) >>> s;
  endfunction

`ifdef CMUL7P8_RR_EN
  logic [IDW-1:0] r_ptr;
  logic           w_hi_vld;
  logic [IDW-1:0] w_hi_idx;
  logic           w_lo_vld;
  logic [IDW-1:0] w_lo_idx;

  // Round-robin: prefer the lowest requester above the pointer, else wrap to the lowest overall.
  always_comb begin
    w_hi_vld = 1'b0;
    w_hi_idx = '0;
    w_lo_vld = 1'b0;
    w_lo_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_lo_vld = 1'b1;
        w_lo_idx = IDW'(i);
        if (i > int'(r_ptr)) begin
          w_hi_vld = 1'b1;
          w_hi_idx = IDW'(i);
        end
      end
    end
    w_grant_vld = w_lo_vld;
    w_grant     = w_hi_vld ? w_hi_idx : w_lo_idx;
  end
`else
  // Fixed priority: the lowest asserted index wins.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_grant_vld = 1'b1;
        w_grant     = IDW'(i);
      end
    end
  end
`endif

  // Select the winner's operand and mode.
  always_comb begin
    w_x_sel    = '0;
    w_mode_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (IDW'(i) == w_grant) begin
        w_x_sel    = x_in[i*W +: W];
        w_mode_sel = mode_in[2*i +: 2];
      end
    end
  end

  assign w_x_ext = {{(DW - W){r_x[W-1]}}, r_x};

  // One shift/add step per state, chosen by the latched mode.
  always_comb begin
    w_acc_d = r_acc;
    w_tmp_d = r_tmp;
    case (r_state)
      StS1: begin
        case (r_mode)
          2'd0:    w_acc_d = w_x_ext <<< 3;
          2'd1:    w_tmp_d = f_div(w_x_ext, 3);
          2'd2:    w_acc_d = f_div(w_x_ext, 1);
          default: w_tmp_d = f_div(w_x_ext, 3);
        endcase
      end
      StS2: begin
        case (r_mode)
          2'd0:    w_acc_d = r_acc - w_x_ext;
          2'd1:    w_acc_d = r_tmp <<< 3;
          2'd2:    w_acc_d = r_acc + f_div(w_x_ext, 2);
          default: w_acc_d = w_x_ext - r_tmp;
        endcase
      end
      StS3: begin
        case (r_mode)
          2'd0:    w_acc_d = f_div(r_acc, 3);
          2'd1:    w_acc_d = r_acc - r_tmp;
          2'd2:    w_acc_d = r_acc + f_div(w_x_ext, 3);
          default: w_acc_d = r_acc;
        endcase
      end
      default: ;
    endcase
  end

  // Sequencer: grant, three ALU steps, then hold the result until accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_x         <= '0;
      r_mode      <= '0;
      r_id        <= '0;
      r_acc       <= '0;
      r_tmp       <= '0;
      r_ack       <= '0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_y     <= '0;
      r_out_id    <= '0;
`ifdef CMUL7P8_RR_EN
      r_ptr       <= IDW'(N - 1);
`endif
    end else begin
      r_ack <= '0;
      r_acc <= w_acc_d;
      r_tmp <= w_tmp_d;
      case (r_state)
        StIdle: begin
          if (w_grant_vld) begin
            r_x            <= signed'(w_x_sel);
            r_mode         <= w_mode_sel;
            r_id           <= w_grant;
            r_ack[w_grant] <= 1'b1;
            r_busy         <= 1'b1;
            r_state        <= StS1;
`ifdef CMUL7P8_RR_EN
            r_ptr          <= w_grant;
`endif
          end
        end
        StS1: r_state <= StS2;
        StS2: r_state <= StS3;
        StS3: begin
          r_out_y     <= w_acc_d[W-1:0];
          r_out_id    <= r_id;
          r_out_valid <= 1'b1;
          r_state     <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign ack       = r_ack;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_y     = r_out_y;
  assign out_id    = r_out_id;

endmodule

// File: tb/tb_cmul7p8_sched.sv
// Self-checking bench for cmul7p8_sched: directed corner cases, arbitration,
// back-pressure, mid-operation reset and random operands against a plain-arithmetic model.
module tb_cmul7p8_sched;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [19:0] x_in;
  logic [7:0]  mode_in;
  logic [3:0]  ack;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_y;
  logic [1:0]  out_id;

  int n_vec = 0;
  int n_err = 0;
  int last_g = 3;
  int slot_x[4];
  int slot_m[4];

  cmul7p8_sched #(.N(4), .W(5), .IDW(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .x_in      (x_in),
    .mode_in   (mode_in),
    .ack       (ack),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_id    (out_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the four 7/8 variants with truncating integer division.
  function automatic int model(input int x, input int m);
    case (m)
      0:       return (7 * x) / 8;
      1:       return (x / 8) * 7;
      2:       return x / 2 + x / 4 + x / 8;
      default: return x - x / 8;
    endcase
  endfunction

  function automatic int exp_grant(input int last);
`ifdef CMUL7P8_RR_EN
    return (last + 1) % 4;
`else
    return 0 + (last & 0);
`endif
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_slot(input int id, input int x, input int m);
    slot_x[id] = x;
    slot_m[id] = m;
    x_in[id*5 +: 5]    = 5'(x);
    mode_in[id*2 +: 2] = 2'(m);
  endtask

  // Wait (bounded) for a grant; returns the acknowledged index or -1.
  task automatic wait_ack(output int g);
    int n;
    n = 0;
    step();
    while (ack === 4'b0000 && n < 12) begin
      step();
      n++;
    end
    g = -1;
    for (int i = 3; i >= 0; i--) if (ack[i] === 1'b1) g = i;
    chk("ack_latency", n, 0);
    chk("busy_on_grant", {31'b0, busy}, 1);
  endtask

  // From the S1 cycle onward: pulse width, latency, result, optional back-pressure.
  task automatic finish_op(input int id, input int expy, input int hold,
                           input logic [3:0] side_req);
    req[id]   = 1'b0;
    out_ready = (hold == 0);
    step();
    chk("ack_pulse", {28'b0, ack}, 0);
    chk("valid_early1", {31'b0, out_valid}, 0);
    step();
    chk("valid_early2", {31'b0, out_valid}, 0);
    step();
    chk("valid_at_k4", {31'b0, out_valid}, 1);
    chk("out_y", $signed(out_y), expy);
    chk("out_id", {30'b0, out_id}, id);
    if (hold > 0) begin
      req = req | side_req;
      for (int h = 0; h < hold; h++) begin
        step();
        chk("hold_valid", {31'b0, out_valid}, 1);
        chk("hold_y", $signed(out_y), expy);
        chk("hold_id", {30'b0, out_id}, id);
        chk("hold_no_ack", {28'b0, ack}, 0);
      end
      out_ready = 1'b1;
    end
    step();
    chk("valid_drop", {31'b0, out_valid}, 0);
    chk("busy_drop", {31'b0, busy}, 0);
  endtask

  task automatic run_op(input int id, input int x, input int m, input int hold,
                        input logic [3:0] side_req);
    int g;
    load_slot(id, x, m);
    req[id] = 1'b1;
    wait_ack(g);
    chk("grant_id", g, id);
    chk("ack_onehot", {28'b0, ack}, 32'(1) << id);
    last_g = id;
    finish_op(id, model(x, m), hold, side_req);
  endtask

  initial begin
    int g;
    int xs[4];
    xs = '{-9, 15, -16, 0};
    reset     = 1'b1;
    req       = '0;
    x_in      = '0;
    mode_in   = '0;
    out_ready = 1'b1;
    repeat (3) step();
    chk("rst_ack", {28'b0, ack}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_y", $signed(out_y), 0);
    chk("rst_id", {30'b0, out_id}, 0);
    reset = 1'b0;
    step();
    chk("idle_no_req", {31'b0, busy}, 0);

    // Directed operands across all modes.
    for (int i = 0; i < 4; i++)
      for (int m = 0; m < 4; m++) run_op(0, xs[i], m, 0, 4'b0000);

    // Back-pressure with requester 1 waiting; it is granted right after the handshake.
    load_slot(1, -5, 0);
    run_op(0, 7, 1, 6, 4'b0010);
    wait_ack(g);
    chk("pending_grant", g, 1);
    last_g = 1;
    finish_op(1, model(-5, 0), 0, 4'b0000);

    // All requesters contending; each re-requests after its result is taken.
    for (int i = 0; i < 4; i++) load_slot(i, int'($urandom_range(0, 31)) - 16,
                                          int'($urandom_range(0, 3)));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int eg;
      eg = exp_grant(last_g);
      wait_ack(g);
      chk("arb_grant", g, eg);
      last_g = eg;
      finish_op(eg, model(slot_x[eg], slot_m[eg]), 0, 4'b0000);
      if (k < 4) req[eg] = 1'b1;
    end
    req = '0;
    step();

    // Reset during S2 of a mode 2 op aborts it silently.
    load_slot(2, -11, 2);
    req[2] = 1'b1;
    wait_ack(g);
    chk("pre_rst_grant", g, 2);
    req[2] = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("abort_ack", {28'b0, ack}, 0);
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_valid", {31'b0, out_valid}, 0);
    chk("abort_y", $signed(out_y), 0);
    chk("abort_id", {30'b0, out_id}, 0);
    reset  = 1'b0;
    last_g = 3;
    repeat (4) begin
      step();
      chk("abort_quiet", {31'b0, out_valid}, 0);
    end
    run_op(2, -11, 2, 0, 4'b0000);

    // Random single-requester traffic.
    for (int k = 0; k < 40; k++)
      run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)) - 16,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
